// File: rtl/iob_axi2ram_pkg.sv
// Shared types and constants for the AXI4-to-single-port-RAM subordinate.
package iob_axi2ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WRESP = 2'd2,
    READ  = 2'd3
  } axi2ram_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_AXI_DATA_W = 32;
  localparam int DEF_RAM_ADDR_W = 12;

endpackage

// File: rtl/iob_axi2ram.sv
// AXI4 subordinate serving word-addressed INCR bursts from a single-port
// synchronous RAM. One burst in flight; reads stream one beat per clock.
//
// state | meaning
// IDLE  | arbitrate AW/AR, latch burst parameters
// WRITE | accept W beats, one RAM write per beat
// WRESP | present B response until bready
// READ  | issue RAM reads, stream R beats until rlast handshake
module iob_axi2ram
  import iob_axi2ram_pkg::*;
#(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = DEF_AXI_DATA_W,
  parameter int AXI_LEN_W  = 8,
  parameter int RAM_ADDR_W = DEF_RAM_ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    cke_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_ADDR_W-3:0]   axi_awaddr_i,
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic [2:0]              axi_awsize_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic                    axi_awlock_i,
  input  logic [3:0]              axi_awcache_i,
  input  logic [3:0]              axi_awqos_i,
  input  logic [2:0]              axi_awprot_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  output logic [1:0]              axi_bresp_o,
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  input  logic [AXI_ADDR_W-3:0]   axi_araddr_i,
  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic [2:0]              axi_arsize_i,
  input  logic [1:0]              axi_arburst_i,
  input  logic                    axi_arlock_i,
  input  logic [3:0]              axi_arcache_i,
  input  logic [3:0]              axi_arqos_i,
  input  logic [2:0]              axi_arprot_i,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic                    axi_rlast_o,
  output logic                    ram_en_o,
  output logic [AXI_DATA_W/8-1:0] ram_we_o,
  output logic [RAM_ADDR_W-1:0]   ram_addr_o,
  output logic [AXI_DATA_W-1:0]   ram_wdata_o,
  input  logic [AXI_DATA_W-1:0]   ram_rdata_i
);

  axi2ram_state_e r_state, w_state_nxt;

  logic [RAM_ADDR_W-1:0] r_addr;
  logic [AXI_LEN_W-1:0]  r_cnt;
  logic [AXI_LEN_W-1:0]  r_len;
  logic [AXI_ID_W-1:0]   r_id;
  logic                  r_err;
  logic                  r_prio;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic                  r_rd_done;

  logic                    w_awready, w_arready, w_wready, w_bvalid;
  logic                    w_wbeat, w_issue, w_rhs;
  logic                    w_ram_en;
  logic [AXI_DATA_W/8-1:0] w_ram_we;
  logic [AXI_DATA_W-1:0]   w_ram_wdata;
  logic                    w_unused;

  // State register; burst abort on reset simply drops back to IDLE.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)   r_state <= IDLE;
    else if (cke_i) r_state <= w_state_nxt;
  end

  // Next-state, handshakes and RAM strobes; everything is gated by cke_i so
  // no handshake can complete while the registers are frozen.
  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_arready   = 1'b0;
    w_wready    = 1'b0;
    w_bvalid    = 1'b0;
    w_wbeat     = 1'b0;
    w_issue     = 1'b0;
    w_rhs       = 1'b0;
    w_ram_en    = 1'b0;
    w_ram_we    = '0;
    w_ram_wdata = '0;
    case (r_state)
      IDLE: begin
        if (axi_awvalid_i && (!axi_arvalid_i || !r_prio)) w_awready = cke_i;
        else if (axi_arvalid_i)                             w_arready = cke_i;
        if (w_awready)      w_state_nxt = WRITE;
        else if (w_arready) w_state_nxt = READ;
      end
      WRITE: begin
        w_wready = cke_i;
        if (axi_wvalid_i && cke_i) begin
          w_wbeat     = 1'b1;
          w_ram_en    = 1'b1;
          w_ram_we    = axi_wstrb_i;
          w_ram_wdata = axi_wdata_i;
          if (r_cnt == r_len) w_state_nxt = WRESP;
        end
      end
      WRESP: begin
        w_bvalid = cke_i;
        if (axi_bready_i && cke_i) w_state_nxt = IDLE;
      end
      READ: begin
        w_rhs    = r_rvalid && axi_rready_i && cke_i;
        w_issue  = !r_rd_done && (!r_rvalid || axi_rready_i) && cke_i;
        w_ram_en = w_issue;
        if (w_rhs && r_rlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: shared address/beat counter, response error and
  // the read-side valid/last pipeline stage.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_addr    <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_id      <= '0;
      r_err     <= 1'b0;
      r_prio    <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rd_done <= 1'b0;
    end else if (cke_i) begin
      if (w_awready || w_arready) begin
        r_addr    <= w_awready ? axi_awaddr_i[RAM_ADDR_W-1:0] : axi_araddr_i[RAM_ADDR_W-1:0];
        r_len     <= w_awready ? axi_awlen_i : axi_arlen_i;
        r_id      <= w_awready ? axi_awid_i : axi_arid_i;
        r_cnt     <= '0;
        r_err     <= 1'b0;
        r_prio    <= ~r_prio;
        r_rd_done <= 1'b0;
        r_rlast   <= 1'b0;
      end
      if (w_wbeat) begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
        r_err  <= r_err | (axi_wlast_i ^ (r_cnt == r_len));
      end
      // rd_done flags the final issue so cnt may wrap at len = all ones.
      if (w_issue) begin
        r_addr    <= r_addr + 1'b1;
        r_cnt     <= r_cnt + 1'b1;
        r_rlast   <= (r_cnt == r_len);
        r_rd_done <= (r_cnt == r_len);
      end
      if (w_issue)    r_rvalid <= 1'b1;
      else if (w_rhs) r_rvalid <= 1'b0;
    end
  end

  assign axi_awready_o = w_awready;
  assign axi_arready_o = w_arready;
  assign axi_wready_o  = w_wready;
  assign axi_bvalid_o  = w_bvalid;
  assign axi_bresp_o   = (w_bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign axi_bid_o     = r_id;
  assign axi_rvalid_o  = r_rvalid && cke_i;
  assign axi_rdata_o   = r_rvalid ? ram_rdata_i : '0;
  assign axi_rresp_o   = RESP_OKAY;
  assign axi_rid_o     = r_id;
  assign axi_rlast_o   = r_rvalid && r_rlast;
  assign ram_en_o      = w_ram_en;
  assign ram_we_o      = w_ram_we;
  assign ram_addr_o    = r_addr;
  assign ram_wdata_o   = w_ram_wdata;

  // Size/burst/attribute fields and the address bits above the RAM are
  // deliberately ignored: every burst is INCR of 4-byte words.
  assign w_unused = ^{axi_awsize_i, axi_awburst_i, axi_awlock_i, axi_awcache_i,
                      axi_awqos_i, axi_awprot_i, axi_arsize_i, axi_arburst_i,
                      axi_arlock_i, axi_arcache_i, axi_arqos_i, axi_arprot_i,
                      axi_awaddr_i[AXI_ADDR_W-3:RAM_ADDR_W],
                      axi_araddr_i[AXI_ADDR_W-3:RAM_ADDR_W]};

endmodule

// File: tb/tb_iob_axi2ram.sv
// Bench for iob_axi2ram: behavioural RAM, reference memory image and
// transaction-level checks of data, responses and handshake latencies.
module tb_iob_axi2ram;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic cke = 1'b1;

  logic        awvalid = 0, awready;
  logic [29:0] awaddr = '0;
  logic        awid = 0;
  logic [7:0]  awlen = '0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic        bid;
  logic        arvalid = 0, arready;
  logic [29:0] araddr = '0;
  logic        arid = 0;
  logic [7:0]  arlen = '0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rid, rlast;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int aw_cyc = 0;
  int ar_cyc = 0;

  iob_axi2ram dut (
    .clk_i(clk), .arst_ni(arst_n), .cke_i(cke),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready), .axi_awaddr_i(awaddr),
    .axi_awid_i(awid), .axi_awlen_i(awlen), .axi_awsize_i(3'd2), .axi_awburst_i(2'd1),
    .axi_awlock_i(1'b0), .axi_awcache_i(4'd0), .axi_awqos_i(4'd0), .axi_awprot_i(3'd0),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready), .axi_wdata_i(wdata),
    .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
    .axi_bvalid_o(bvalid), .axi_bready_i(bready), .axi_bresp_o(bresp), .axi_bid_o(bid),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready), .axi_araddr_i(araddr),
    .axi_arid_i(arid), .axi_arlen_i(arlen), .axi_arsize_i(3'd2), .axi_arburst_i(2'd1),
    .axi_arlock_i(1'b0), .axi_arcache_i(4'd0), .axi_arqos_i(4'd0), .axi_arprot_i(3'd0),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready), .axi_rdata_o(rdata),
    .axi_rresp_o(rresp), .axi_rid_o(rid), .axi_rlast_o(rlast),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0000_9E37);
  endfunction

  // Behavioural single-port RAM, preloaded on its first clock.
  logic [31:0] mem [0:4095];
  bit mem_init_done;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (ram_en) begin
      if (ram_we == 4'h0) ram_rdata <= mem[ram_addr];
      else for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // Reference image of what the RAM must hold after each AXI write.
  logic [31:0] ref_mem [0:4095];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic aw_phase(input logic [29:0] addr, input int len, input logic id);
    int to = 0;
    awvalid = 1; awaddr = addr; awlen = 8'(len); awid = id;
    #1;
    while (!awready && to < 50) begin @(negedge clk); #1; to++; end
    chk("aw_handshake", awready, 1);
    aw_cyc = cyc;
    @(negedge clk);
    awvalid = 0;
  endtask

  task automatic ar_phase(input logic [29:0] addr, input int len, input logic id);
    int to = 0;
    arvalid = 1; araddr = addr; arlen = 8'(len); arid = id;
    #1;
    while (!arready && to < 50) begin @(negedge clk); #1; to++; end
    chk("ar_handshake", arready, 1);
    ar_cyc = cyc;
    @(negedge clk);
    arvalid = 0;
  endtask

  task automatic w_phase(input logic [29:0] addr, input int len, input logic id,
                         input int wlast_at, input logic [31:0] d0, input bit rnd,
                         input logic [1:0] exp_resp);
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0] s;
    int to;
    for (int i = 0; i <= len; i++) begin
      if (rnd && i > 0 && $urandom_range(0, 3) == 0) @(negedge clk);
      a = addr[11:0] + 12'(i);
      d = rnd ? $urandom : d0 + 32'(i);
      s = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
      wvalid = 1; wdata = d; wstrb = s; wlast = (i == wlast_at);
      #1;
      to = 0;
      while (!wready && to < 50) begin @(negedge clk); #1; to++; end
      if (!wready) begin
        chk("w_timeout", 0, 1);
        wvalid = 0;
        return;
      end
      if (i == 0) chk("wready_latency", 64'(cyc - aw_cyc), 1);
      chk("ram_en_w", ram_en, 1);
      chk("ram_we", ram_we, s);
      chk("ram_addr_w", ram_addr, a);
      chk("ram_wdata", ram_wdata, d);
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      @(negedge clk);
      wvalid = 0; wlast = 0;
    end
    #1;
    chk("bvalid_latency", bvalid, 1);
    chk("bresp", bresp, exp_resp);
    chk("bid", bid, id);
    bready = 1;
    @(negedge clk);
    bready = 0;
    #1;
    chk("bvalid_cleared", bvalid, 0);
  endtask

  // mode 0: rready held high; 1: rready 1,0,0 repeating; 2: random
  task automatic r_phase(input logic [29:0] addr, input int len, input logic id, input int mode);
    int k = 0, to = 0, first = -1, lastc = -1, pat = 0;
    bit pv = 0;
    logic [31:0] pd = '0;
    while (k <= len && to < 2000) begin
      case (mode)
        0:       rready = 1;
        1:       rready = (pat % 3 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (rvalid && first < 0) first = cyc;
      if (pv) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", rdata, pd);
      end
      if (rvalid && rready) begin
        chk("rdata", rdata, ref_mem[addr[11:0] + 12'(k)]);
        chk("rlast", rlast, (k == len));
        chk("rid", rid, id);
        chk("rresp", rresp, 0);
        if (k == len) lastc = cyc;
        k++;
      end
      pv = rvalid && !rready;
      pd = rdata;
      pat++; to++;
      @(negedge clk);
    end
    rready = 0;
    if (k <= len) chk("r_timeout", 64'(k), 64'(len + 1));
    chk("r_first_latency", 64'(first - ar_cyc), 2);
    if (mode == 0) chk("r_last_latency", 64'(lastc - ar_cyc), 64'(2 + len));
    #1;
    chk("rvalid_after_burst", rvalid, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    int          len;
    logic        id;
    int          wlast_at;
    logic [31:0] data0;
    int          rmode;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic run_vec(input vec_t v, input bit rnd);
    @(negedge clk);
    if (v.wr) begin
      aw_phase(v.addr, v.len, v.id);
      w_phase(v.addr, v.len, v.id, v.wlast_at, v.data0, rnd, v.exp_resp);
    end else begin
      ar_phase(v.addr, v.len, v.id);
      r_phase(v.addr, v.len, v.id, v.rmode);
    end
  endtask

  vec_t vecs [12];

  initial begin
    vec_t rv;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    vecs[0]  = '{1, 30'h010, 0,   1, 0,   32'hDEADBEEF, 0, 2'b00};
    vecs[1]  = '{0, 30'h010, 3,   0, 0,   32'h0,        0, 2'b00};
    vecs[2]  = '{0, 30'h010, 3,   1, 0,   32'h0,        1, 2'b00};
    vecs[3]  = '{1, 30'h020, 3,   0, 1,   32'h2000_0000, 0, 2'b10};
    vecs[4]  = '{0, 30'h020, 3,   0, 0,   32'h0,        0, 2'b00};
    vecs[5]  = '{1, 30'hFFF, 1,   1, 1,   32'h5A5A_0000, 0, 2'b00};
    vecs[6]  = '{0, 30'hFFF, 1,   1, 0,   32'h0,        1, 2'b00};
    vecs[7]  = '{1, 30'h5100, 2,  0, 2,   32'h0100_0000, 0, 2'b00};
    vecs[8]  = '{0, 30'h100, 2,   0, 0,   32'h0,        2, 2'b00};
    vecs[9]  = '{1, 30'h300, 3,   1, -1,  32'h0300_0000, 0, 2'b10};
    vecs[10] = '{1, 30'h400, 255, 0, 255, 32'h0400_0000, 0, 2'b00};
    vecs[11] = '{0, 30'h400, 255, 1, 0,   32'h0,        0, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {awready, arready, wready, bvalid, rvalid, rlast, ram_en,
                          ram_we, bresp, rresp, rdata}, 0);
    arst_n = 1;

    // Simultaneous AW and AR twice: first grant write, second grant read
    @(negedge clk);
    awvalid = 1; awaddr = 30'h40; awlen = 0; awid = 1;
    arvalid = 1; araddr = 30'h40; arlen = 0; arid = 0;
    #1;
    chk("prio1_awready", awready, 1);
    chk("prio1_arready", arready, 0);
    aw_cyc = cyc;
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    w_phase(30'h40, 0, 1, 0, 32'h1111_2222, 0, 2'b00);
    @(negedge clk);
    awvalid = 1; awaddr = 30'h41; awlen = 0; awid = 1;
    arvalid = 1; araddr = 30'h40; arlen = 0; arid = 0;
    #1;
    chk("prio2_awready", awready, 0);
    chk("prio2_arready", arready, 1);
    ar_cyc = cyc;
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    r_phase(30'h40, 0, 0, 0);
    @(negedge clk);
    aw_phase(30'h41, 0, 1);
    w_phase(30'h41, 0, 1, 0, 32'h3333_4444, 0, 2'b00);

    // Table-driven directed transactions
    for (int i = 0; i < 12; i++) run_vec(vecs[i], 0);

    // Reset in the middle of a long read
    @(negedge clk);
    ar_phase(30'h400, 255, 1);
    rready = 1;
    repeat (5) @(negedge clk);
    arst_n = 0;
    #1;
    chk("midreset_outputs", {awready, arready, wready, bvalid, rvalid, rlast, ram_en,
                             ram_we, bresp, rresp, rdata, ram_addr, rid, bid}, 0);
    rready = 0;
    @(negedge clk);
    arst_n = 1;
    run_vec('{1, 30'h200, 1, 1, 1, 32'h0200_0000, 0, 2'b00}, 0);
    run_vec('{0, 30'h200, 1, 1, 0, 32'h0, 0, 2'b00}, 0);

    // Randomized traffic against the reference image
    for (int n = 0; n < 40; n++) begin
      rv.wr = 1'($urandom_range(0, 1));
      rv.addr = 30'($urandom);
      rv.len = $urandom_range(0, 7);
      rv.id = 1'($urandom_range(0, 1));
      rv.wlast_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rv.len) : rv.len;
      rv.data0 = $urandom;
      rv.rmode = 2;
      rv.exp_resp = (rv.wlast_at == rv.len) ? 2'b00 : 2'b10;
      run_vec(rv, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
